// File: rtl/rx_frame_check.sv
// rtl/rx_frame_check.sv - serial frame receiver with parity/stop checking and error counters
// Line bits are consumed only on i_BitValid strobes; results register one cycle after the last stop bit.
module rx_frame_check #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              i_Pclk,
  input  logic              i_Rstn,
  input  logic              i_BitValid,
  input  logic              i_Bit,
  input  logic [2:0]        i_Parity,
  input  logic              i_Stop2,
  input  logic              i_ClrCnt,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Valid,
  output logic              o_ParityOK,
  output logic              o_FrameOK,
  output logic              o_Busy,
  output logic [CNT_W-1:0]  o_ParErrCnt,
  output logic [CNT_W-1:0]  o_FrmErrCnt
);
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bitcnt;
  logic [2:0]        r_mode;
  logic              r_stop2, r_parbit, r_stop_bad;
  logic              w_has_par, w_last_data, w_done, w_par_ok, w_frame_ok;

  assign w_has_par   = (r_mode >= 3'd1) && (r_mode <= 3'd4);
  assign w_last_data = (r_bitcnt == BC_W'(DATA_W - 1));
  assign w_done      = i_BitValid && (((r_state == S_STOP1) && !r_stop2) || (r_state == S_STOP2));
  assign w_frame_ok  = !r_stop_bad && i_Bit;
  assign o_Busy      = (r_state != S_IDLE);

  always_comb begin
    w_par_ok = 1'b1;
    case (r_mode)
      3'd1:    w_par_ok = ~(^r_shift ^ r_parbit);
      3'd2:    w_par_ok = ^r_shift ^ r_parbit;
      3'd3:    w_par_ok = r_parbit;
      3'd4:    w_par_ok = ~r_parbit;
      default: w_par_ok = 1'b1;
    endcase
  end

  always_ff @(posedge i_Pclk) begin
    if (!i_Rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_BitValid) begin
      case (r_state)
        S_IDLE:   if (!i_Bit) w_next = S_DATA;
        S_DATA:   if (w_last_data) w_next = w_has_par ? S_PARITY : S_STOP1;
        S_PARITY: w_next = S_STOP1;
        S_STOP1:  w_next = r_stop2 ? S_STOP2 : S_IDLE;
        S_STOP2:  w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Mode and stop count are frozen at the start bit so mid-frame input changes are ignored.
  always_ff @(posedge i_Pclk) begin
    if (!i_Rstn) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_mode     <= 3'd0;
      r_stop2    <= 1'b0;
      r_parbit   <= 1'b0;
      r_stop_bad <= 1'b0;
    end else if (i_BitValid) begin
      case (r_state)
        S_IDLE: if (!i_Bit) begin
          r_bitcnt   <= '0;
          r_mode     <= i_Parity;
          r_stop2    <= i_Stop2;
          r_stop_bad <= 1'b0;
        end
        S_DATA: begin
          r_shift  <= {i_Bit, r_shift[DATA_W-1:1]};
          r_bitcnt <= r_bitcnt + BC_W'(1);
        end
        S_PARITY: r_parbit <= i_Bit;
        S_STOP1:  if (!i_Bit) r_stop_bad <= 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (!i_Rstn) begin
      o_Valid    <= 1'b0;
      o_Data     <= '0;
      o_ParityOK <= 1'b1;
      o_FrameOK  <= 1'b1;
    end else begin
      o_Valid <= w_done;
      if (w_done) begin
        o_Data     <= w_par_ok ? r_shift : '0;
        o_ParityOK <= w_par_ok;
        o_FrameOK  <= w_frame_ok;
      end
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (!i_Rstn || i_ClrCnt) begin
      o_ParErrCnt <= '0;
      o_FrmErrCnt <= '0;
    end else if (w_done) begin
      if (!w_par_ok && (o_ParErrCnt != CNT_MAX))   o_ParErrCnt <= o_ParErrCnt + CNT_W'(1);
      if (!w_frame_ok && (o_FrmErrCnt != CNT_MAX)) o_FrmErrCnt <= o_FrmErrCnt + CNT_W'(1);
    end
  end

endmodule
